// File: rtl/demux2_stream.sv
// rtl/demux2_stream.sv - registered 1-to-2 stream demultiplexer with per-output FIFOs
module demux2_stream #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CW-1:0]    out0_count,
    output logic [CW-1:0]    out1_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [1:0][CW-1:0]    count;
    logic [1:0][WIDTH-1:0] head;
    logic [1:0]            sel_hot;
    logic [1:0]            out_ready;
    logic [1:0]            push;
    logic [1:0]            pop;

    // Ready looks only at the selected channel's occupancy, so one full
    // channel never stalls traffic headed for the other one.
    assign in_ready  = !reset && (in_sel ? (count[1] < FULL_COUNT) : (count[0] < FULL_COUNT));
    assign sel_hot   = {in_sel, !in_sel};
    assign out_ready = {out1_ready, out0_ready};

    for (genvar k = 0; k < 2; k++) begin : g_chan
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    wptr;
        logic [PW-1:0]    rptr;

        // A full channel refuses the push even when it pops on the same edge.
        assign push[k] = in_valid && in_ready && sel_hot[k];
        assign pop[k]  = (count[k] != '0) && out_ready[k];
        assign head[k] = mem[rptr];

        // Storage write and write-pointer advance; reset wipes all entries.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
                wptr <= '0;
            end else if (push[k]) begin
                mem[wptr] <= in_data;
                wptr      <= (wptr == LAST_PTR) ? '0 : wptr + PW'(1);
            end
        end

        // Read-pointer advance on each accepted output transfer.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rptr <= '0;
            end else if (pop[k]) begin
                rptr <= (rptr == LAST_PTR) ? '0 : rptr + PW'(1);
            end
        end

        // Occupancy tracking; a simultaneous push and pop leaves it unchanged.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                count[k] <= '0;
            end else begin
                case ({push[k], pop[k]})
                    2'b10:   count[k] <= count[k] + CW'(1);
                    2'b01:   count[k] <= count[k] - CW'(1);
                    default: count[k] <= count[k];
                endcase
            end
        end
    end

    assign out0_valid = (count[0] != '0);
    assign out1_valid = (count[1] != '0);
    assign out0_data  = head[0];
    assign out1_data  = head[1];
    assign out0_count = count[0];
    assign out1_count = count[1];

endmodule
